// File: rtl/speed_conv_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : speed_conv_sched_if
// Purpose  : Bundles the requester handshakes, the converter drive/return
//            path and the completion signals of speed_conv_sched.
// Ports    : req0/spd0_in, req1/spd1_in      requester side (to scheduler)
//            gnt0/gnt1, done0/done1          one-cycle pulses (from scheduler)
//            result[15:0], err, busy         completion data / status
//            conv_ready, conv_spd[47:0]      converter drive (from scheduler)
//            conv_mph_x100[15:0]             converter output (to scheduler)
// Modports : slave  - the scheduler itself
//            master - requesters plus converter
// Revision : 1.0  initial release
// ============================================================================
interface speed_conv_sched_if;
  logic        req0;
  logic [47:0] spd0_in;
  logic        req1;
  logic [47:0] spd1_in;
  logic        gnt0;
  logic        gnt1;
  logic        conv_ready;
  logic [47:0] conv_spd;
  logic [15:0] conv_mph_x100;
  logic        done0;
  logic        done1;
  logic [15:0] result;
  logic        err;
  logic        busy;

  modport slave (
    input  req0, spd0_in, req1, spd1_in, conv_mph_x100,
    output gnt0, gnt1, conv_ready, conv_spd, done0, done1, result, err, busy
  );

  modport master (
    output req0, spd0_in, req1, spd1_in, conv_mph_x100,
    input  gnt0, gnt1, conv_ready, conv_spd, done0, done1, result, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/speed_conv_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : speed_conv_sched
// Purpose  : Shares one knots-to-mph converter between the RMC (requester 0)
//            and VTG (requester 1) speed paths. Round-robin arbitration,
//            ASCII field validation, repeated-strobe converter drive, and
//            result/err return with a done pulse to the owning requester.
// Ports    : clk            system clock, rising edge
//            rst            asynchronous active-low reset
//            bus (slave)    requests/fields in, grants/dones/result/err/busy
//                           out, converter strobe/operand out, mph_x100 in
// Params   : PULSES         consecutive conv_ready cycles per job (1..7)
// Revision : 1.0  initial release
// ============================================================================
module speed_conv_sched #(
  parameter int unsigned PULSES = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  speed_conv_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_REJECT = 2'd3
  } state_t;

  // Count value seen on the final strobe cycle of ISSUE.
  localparam logic [2:0] LAST_CNT = 3'(PULSES - 1);

  state_t      state_q,  state_d;
  logic [2:0]  cnt_q,    cnt_d;
  logic        last_q,   last_d;   // 1 = requester 1 was granted last
  logic        owner_q,  owner_d;  // requester that owns the running job
  logic [47:0] spd_q,    spd_d;
  logic        gnt0_q,   gnt0_d;
  logic        gnt1_q,   gnt1_d;
  logic        done0_q,  done0_d;
  logic        done1_q,  done1_d;
  logic [15:0] result_q, result_d;
  logic        err_q,    err_d;

  logic        pick1;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // Only the four leading bytes are checked; bytes 4/5 pass through as-is.
  function automatic logic field_ok(input logic [31:0] hdr);
    return is_digit(hdr[31:24]) &&
           (is_digit(hdr[23:16]) || (hdr[23:16] == 8'h2E)) &&
           is_digit(hdr[15:8]) &&
           is_digit(hdr[7:0]);
  endfunction

  // Requester 1 wins when alone, or on a tie when requester 0 went last.
  assign pick1 = bus.req1 && (!bus.req0 || !last_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner_q;
    spd_d    = spd_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    result_d = result_q;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_d = pick1;
          last_d  = pick1;
          spd_d   = pick1 ? bus.spd1_in : bus.spd0_in;
          gnt0_d  = !pick1;
          gnt1_d  = pick1;
          cnt_d   = 3'd0;
          state_d = field_ok(spd_d[47:16]) ? S_ISSUE : S_REJECT;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        result_d = bus.conv_mph_x100;
        err_d    = 1'b0;
        done0_d  = !owner_q;
        done1_d  = owner_q;
        state_d  = S_IDLE;
      end
      S_REJECT: begin
        result_d = 16'd0;
        err_d    = 1'b1;
        done0_d  = !owner_q;
        done1_d  = owner_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      spd_q    <= 48'd0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      spd_q    <= spd_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Strobe and busy decode straight from state so an async reset drops
  // them without waiting for a clock edge.
  assign bus.conv_ready = (state_q == S_ISSUE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.conv_spd   = spd_q;
  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.done0      = done0_q;
  assign bus.done1      = done1_q;
  assign bus.result     = result_q;
  assign bus.err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_speed_conv_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_speed_conv_sched
// Purpose  : Directed self-checking bench for speed_conv_sched with a
//            two-stage knots-to-mph converter model (mph_x100 = kn_x100*115/100).
// Revision : 1.0  initial release
// ============================================================================
module tb_speed_conv_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [47:0] F_500 = "5.00  ";
  localparam logic [47:0] F_999 = "9.99  ";
  localparam logic [47:0] F_100 = "1.00  ";

  speed_conv_sched_if ifc0();
  speed_conv_sched_if ifc1();

  speed_conv_sched #(.PULSES(2)) u_dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
  speed_conv_sched #(.PULSES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));

  // Converter model: stage 1 latches the operand, stage 2 converts the
  // previously latched operand; both advance only on speed_ready.
  function automatic logic [15:0] knots_x100(input logic [47:0] f);
    return 16'((f[47:40] - 8'h30) * 100 + (f[31:24] - 8'h30) * 10 + (f[23:16] - 8'h30));
  endfunction

  function automatic logic [15:0] to_mph(input logic [15:0] kn);
    return 16'((32'(kn) * 115) / 100);
  endfunction

  logic [15:0] c0_st, c0_out, c1_st, c1_out;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      c0_st <= 16'd0; c0_out <= 16'd0;
    end else if (ifc0.conv_ready) begin
      c0_st <= knots_x100(ifc0.conv_spd); c0_out <= to_mph(c0_st);
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      c1_st <= 16'd0; c1_out <= 16'd0;
    end else if (ifc1.conv_ready) begin
      c1_st <= knots_x100(ifc1.conv_spd); c1_out <= to_mph(c1_st);
    end
  end

  assign ifc0.conv_mph_x100 = c0_out;
  assign ifc1.conv_mph_x100 = c1_out;

  // Per-cycle samples of DUT0, index k taken 1 ns after edge E(k).
  logic        s_gnt0 [16];
  logic        s_gnt1 [16];
  logic        s_rdy  [16];
  logic        s_d0   [16];
  logic        s_d1   [16];
  logic        s_err  [16];
  logic        s_busy [16];
  logic [15:0] s_res  [16];

  task automatic capture(input int n, input bit drop);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      s_gnt0[k] = ifc0.gnt0;  s_gnt1[k] = ifc0.gnt1;
      s_rdy[k]  = ifc0.conv_ready;
      s_d0[k]   = ifc0.done0; s_d1[k]   = ifc0.done1;
      s_err[k]  = ifc0.err;   s_busy[k] = ifc0.busy;
      s_res[k]  = ifc0.result;
      if (drop && ifc0.gnt0) ifc0.req0 = 1'b0;
      if (drop && ifc0.gnt1) ifc0.req1 = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ifc0.gnt0 !== 1'b0 || ifc0.gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b%b want 00", ifc0.gnt0, ifc0.gnt1); end
    checks++; if (ifc0.done0 !== 1'b0 || ifc0.done1 !== 1'b0 || ifc0.err !== 1'b0) begin errors++; $display("FAIL reset_done_err got %b%b%b want 000", ifc0.done0, ifc0.done1, ifc0.err); end
    checks++; if (ifc0.result !== 16'd0) begin errors++; $display("FAIL reset_result got %0d want 0", ifc0.result); end
    checks++; if (ifc0.conv_spd !== 48'd0) begin errors++; $display("FAIL reset_conv_spd got %h want 0", ifc0.conv_spd); end
    checks++; if (ifc0.conv_ready !== 1'b0 || ifc0.busy !== 1'b0) begin errors++; $display("FAIL reset_rdy_busy got %b%b want 00", ifc0.conv_ready, ifc0.busy); end
    rst = 1'b1;
  endtask

  task automatic test_rmc;
    int n_gnt, n_rdy, n_d0, n_d1;
    ifc0.spd0_in = F_500; ifc0.req0 = 1'b1;
    capture(6, 1'b1);
    n_gnt = 0; n_rdy = 0; n_d0 = 0; n_d1 = 0;
    for (int k = 0; k < 6; k++) begin
      n_gnt += int'(s_gnt0[k]); n_rdy += int'(s_rdy[k]);
      n_d0 += int'(s_d0[k]);    n_d1 += int'(s_d1[k]);
    end
    checks++; if (s_gnt0[0] !== 1'b1 || n_gnt != 1) begin errors++; $display("FAIL rmc_gnt0 got first=%b count=%0d want 1/1", s_gnt0[0], n_gnt); end
    checks++; if (n_rdy != 2 || s_rdy[0] !== 1'b1 || s_rdy[1] !== 1'b1) begin errors++; $display("FAIL rmc_ready got count=%0d want 2 in cycles 0-1", n_rdy); end
    checks++; if (ifc0.conv_spd !== F_500) begin errors++; $display("FAIL rmc_conv_spd got %h want %h", ifc0.conv_spd, F_500); end
    checks++; if (s_d0[3] !== 1'b1 || n_d0 != 1 || n_d1 != 0) begin errors++; $display("FAIL rmc_done got d0@3=%b d0cnt=%0d d1cnt=%0d want 1/1/0", s_d0[3], n_d0, n_d1); end
    checks++; if (s_res[3] !== 16'd575 || s_err[3] !== 1'b0) begin errors++; $display("FAIL rmc_result got %0d err=%b want 575 err=0", s_res[3], s_err[3]); end
    checks++; if (s_res[5] !== 16'd575) begin errors++; $display("FAIL rmc_result_hold got %0d want 575", s_res[5]); end
  endtask

  task automatic test_vtg;
    int n_d0;
    ifc0.spd1_in = F_999; ifc0.req1 = 1'b1;
    capture(6, 1'b1);
    n_d0 = 0;
    for (int k = 0; k < 6; k++) n_d0 += int'(s_d0[k]);
    checks++; if (s_gnt1[0] !== 1'b1 || s_gnt0[0] !== 1'b0) begin errors++; $display("FAIL vtg_gnt got gnt1=%b gnt0=%b want 1/0", s_gnt1[0], s_gnt0[0]); end
    checks++; if (s_d1[3] !== 1'b1 || n_d0 != 0) begin errors++; $display("FAIL vtg_done got d1@3=%b d0cnt=%0d want 1/0", s_d1[3], n_d0); end
    checks++; if (s_res[3] !== 16'd1148 || s_err[3] !== 1'b0) begin errors++; $display("FAIL vtg_result got %0d err=%b want 1148 err=0", s_res[3], s_err[3]); end
  endtask

  task automatic test_back_to_back;
    int n_idle;
    logic own;
    ifc0.spd0_in = F_500; ifc0.spd1_in = F_999;
    ifc0.req0 = 1'b1; ifc0.req1 = 1'b1;
    capture(16, 1'b0);
    ifc0.req0 = 1'b0; ifc0.req1 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      own = (j % 2) == 1;
      checks++; if (s_gnt0[4*j] !== !own || s_gnt1[4*j] !== own) begin errors++; $display("FAIL b2b_gnt job%0d got %b%b want owner %0d", j, s_gnt1[4*j], s_gnt0[4*j], own); end
      checks++; if (s_d0[4*j+3] !== !own || s_d1[4*j+3] !== own) begin errors++; $display("FAIL b2b_done job%0d got %b%b want owner %0d", j, s_d1[4*j+3], s_d0[4*j+3], own); end
      checks++; if (s_res[4*j+3] !== (own ? 16'd1148 : 16'd575)) begin errors++; $display("FAIL b2b_result job%0d got %0d want %0d", j, s_res[4*j+3], own ? 1148 : 575); end
    end
    n_idle = 0;
    for (int k = 0; k < 15; k++) n_idle += int'(!s_busy[k]);
    checks++; if (n_idle != 3 || s_busy[3] !== 1'b0 || s_busy[7] !== 1'b0 || s_busy[11] !== 1'b0) begin errors++; $display("FAIL b2b_busy got idle cycles=%0d want 3 at 3/7/11", n_idle); end
    @(posedge clk); #1;
  endtask

  task automatic test_validity;
    logic [47:0] flds [8];
    logic        xerr [8];
    int idx, n_rdy, want_idx;
    flds = '{"A.00  ", "/.00  ", ":.00  ", "5-00  ", "5.0/  ", "5./0  ", "0.99XY", "5900ZZ"};
    xerr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int r = 0; r < 8; r++) begin
      ifc0.spd0_in = flds[r]; ifc0.req0 = 1'b1;
      capture(6, 1'b1);
      ifc0.req0 = 1'b0;
      idx = -1; n_rdy = 0;
      for (int k = 0; k < 6; k++) begin
        n_rdy += int'(s_rdy[k]);
        if (s_d0[k] && idx < 0) idx = k;
      end
      want_idx = xerr[r] ? 1 : 3;
      checks++; if (idx != want_idx || s_gnt0[0] !== 1'b1) begin errors++; $display("FAIL valid_done row%0d got idx=%0d gnt=%b want idx=%0d gnt=1", r, idx, s_gnt0[0], want_idx); end
      checks++; if (n_rdy != (xerr[r] ? 0 : 2)) begin errors++; $display("FAIL valid_ready row%0d got %0d want %0d", r, n_rdy, xerr[r] ? 0 : 2); end
      if (idx >= 0) begin
        checks++; if (s_err[idx] !== xerr[r] || s_err[idx+1] !== 1'b0) begin errors++; $display("FAIL valid_err row%0d got %b then %b want %b then 0", r, s_err[idx], s_err[idx+1], xerr[r]); end
        if (xerr[r]) begin
          checks++; if (s_res[idx] !== 16'd0) begin errors++; $display("FAIL valid_result row%0d got %0d want 0", r, s_res[idx]); end
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    int n_done;
    ifc0.spd0_in = F_500; ifc0.req0 = 1'b1;
    @(posedge clk); #1;
    ifc0.req0 = 1'b0;
    @(posedge clk); #1;
    checks++; if (ifc0.conv_ready !== 1'b1) begin errors++; $display("FAIL midrst_pre_ready got %b want 1", ifc0.conv_ready); end
    #2 rst = 1'b0;
    #1;
    checks++; if (ifc0.conv_ready !== 1'b0 || ifc0.busy !== 1'b0) begin errors++; $display("FAIL midrst_async got ready=%b busy=%b want 0/0", ifc0.conv_ready, ifc0.busy); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    capture(4, 1'b0);
    n_done = 0;
    for (int k = 0; k < 4; k++) n_done += int'(s_d0[k]) + int'(s_d1[k]);
    checks++; if (n_done != 0 || s_res[0] !== 16'd0) begin errors++; $display("FAIL midrst_no_done got dones=%0d result=%0d want 0/0", n_done, s_res[0]); end
    ifc0.spd0_in = F_100; ifc0.req0 = 1'b1;
    capture(6, 1'b1);
    checks++; if (s_d0[3] !== 1'b1 || s_res[3] !== 16'd115 || s_err[3] !== 1'b0) begin errors++; $display("FAIL midrst_rerun got done=%b result=%0d err=%b want 1/115/0", s_d0[3], s_res[3], s_err[3]); end
  endtask

  task automatic test_pulses1;
    int idx, n_rdy;
    logic [15:0] res;
    for (int job = 0; job < 2; job++) begin
      ifc1.spd0_in = (job == 0) ? F_999 : F_500; ifc1.req0 = 1'b1;
      idx = -1; n_rdy = 0; res = 16'hFFFF;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        if (ifc1.gnt0) ifc1.req0 = 1'b0;
        n_rdy += int'(ifc1.conv_ready);
        if (ifc1.done0 && idx < 0) begin idx = k; res = ifc1.result; end
      end
      ifc1.req0 = 1'b0;
      checks++; if (idx != 2 || n_rdy != 1) begin errors++; $display("FAIL p1_timing job%0d got idx=%0d ready=%0d want 2/1", job, idx, n_rdy); end
      checks++; if (res !== ((job == 0) ? 16'd0 : 16'd1148)) begin errors++; $display("FAIL p1_result job%0d got %0d want %0d", job, res, (job == 0) ? 0 : 1148); end
    end
  endtask

  initial begin
    ifc0.req0 = 1'b0; ifc0.req1 = 1'b0; ifc0.spd0_in = 48'd0; ifc0.spd1_in = 48'd0;
    ifc1.req0 = 1'b0; ifc1.req1 = 1'b0; ifc1.spd0_in = 48'd0; ifc1.spd1_in = 48'd0;
    test_reset;
    test_rmc;
    test_vtg;
    test_back_to_back;
    test_validity;
    test_mid_reset;
    test_pulses1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
